// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 frame feeder.
// Frame cells are addressed by a flat index: row * COLS + col.
package lcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_CHAR,
        ST_DONE
    } feeder_state_t;

    localparam logic [7:0] CMD_SET_DDRAM = 8'h80;
    localparam logic [7:0] CHAR_SPACE    = 8'h20;
    localparam int         MAX_CELLS     = 32;

    function automatic logic [4:0] cell_index(input logic row, input logic [3:0] col, input int cols);
        return row ? 5'(cols) + {1'b0, col} : {1'b0, col};
    endfunction

endpackage

// File: rtl/lcd_frame_ram.sv
// Character frame storage: one synchronous write port, one combinational read port.
// Reset fills every cell with a space.
module lcd_frame_ram
    import lcd_pkg::*;
#(
    parameter int DEPTH = 32
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       we_i,
    input  logic [4:0] wr_idx_i,
    input  logic [7:0] wr_data_i,
    input  logic [4:0] rd_idx_i,
    output logic [7:0] rd_data_o
);

    logic [7:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= CHAR_SPACE;
            end
        end else if (we_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_idx_i == 5'(i)) begin
                    mem_q[i] <= wr_data_i;
                end
            end
        end
    end

    always_comb begin
        rd_data_o = CHAR_SPACE;
        for (int i = 0; i < DEPTH; i++) begin
            if (rd_idx_i == 5'(i)) begin
                rd_data_o = mem_q[i];
            end
        end
    end

endmodule

// File: rtl/lcd_frame_feeder.sv
// Streams a ROWS x COLS character frame to the LCD driver as {rs, data} words:
// per row, one set-DDRAM-address instruction followed by COLS character writes.
module lcd_frame_feeder
    import lcd_pkg::*;
#(
    parameter int         COLS       = 16,
    parameter int         ROWS       = 2,
    parameter logic [7:0] LINE0_ADDR = 8'h00,
    parameter logic [7:0] LINE1_ADDR = 8'h40
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic       wr_row,
    input  logic [3:0] wr_col,
    input  logic [7:0] wr_char,
    input  logic       refresh,
    output logic       busy,
    output logic       cmd_valid,
    output logic       cmd_rs,
    output logic [7:0] cmd_data,
    input  logic       cmd_ready,
    output logic       frame_done
);

    localparam logic [3:0] COL_LAST = 4'(COLS - 1);
    localparam logic       ROW_LAST = 1'(ROWS - 1);

    feeder_state_t state_q, state_d;
    logic       row_q, row_d;
    logic [3:0] col_q, col_d;
    logic       pending_q, pending_d;
    logic       busy_q, busy_d;
    logic       valid_q, valid_d;
    logic       rs_q, rs_d;
    logic [7:0] data_q, data_d;
    logic       done_q, done_d;

    logic       wrInRange;
    logic       handshake;
    logic [7:0] rdChar;

    assign wrInRange = wr_en && (32'(wr_row) < ROWS) && (32'(wr_col) < COLS);
    assign handshake = valid_q && cmd_ready;

    // Read address follows the next counter values so a new character word is
    // captured from the buffer on the same edge that presents it.
    lcd_frame_ram #(
        .DEPTH(ROWS * COLS)
    ) u_ram (
        .clk_i    (clk),
        .rst_i    (rst),
        .we_i     (wrInRange),
        .wr_idx_i (cell_index(wr_row, wr_col, COLS)),
        .wr_data_i(wr_char),
        .rd_idx_i (cell_index(row_d, col_d, COLS)),
        .rd_data_o(rdChar)
    );

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        pending_d = pending_q;
        if (state_q != ST_IDLE && (refresh || wrInRange)) begin
            pending_d = 1'b1;
        end
        case (state_q)
            ST_IDLE: begin
                if (refresh || pending_q) begin
                    state_d   = ST_ADDR;
                    row_d     = 1'b0;
                    col_d     = 4'd0;
                    pending_d = 1'b0;
                end
            end
            ST_ADDR: begin
                if (handshake) begin
                    state_d = ST_CHAR;
                    col_d   = 4'd0;
                end
            end
            ST_CHAR: begin
                if (handshake) begin
                    if (col_q != COL_LAST) begin
                        col_d = col_q + 4'd1;
                    end else if (row_q != ROW_LAST) begin
                        row_d   = row_q + 1'b1;
                        col_d   = 4'd0;
                        state_d = ST_ADDR;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // A fresh word is loaded only on entry to a transfer or after a handshake,
    // which keeps rs/data stable while the driver stalls.
    always_comb begin
        valid_d = (state_d == ST_ADDR) || (state_d == ST_CHAR);
        busy_d  = valid_d;
        done_d  = (state_d == ST_DONE);
        rs_d    = rs_q;
        data_d  = data_q;
        if (!valid_d) begin
            rs_d   = 1'b0;
            data_d = 8'h00;
        end else if (state_q == ST_IDLE || state_q == ST_DONE || handshake) begin
            if (state_d == ST_ADDR) begin
                rs_d   = 1'b0;
                data_d = CMD_SET_DDRAM | {1'b0, (row_d ? LINE1_ADDR[6:0] : LINE0_ADDR[6:0])};
            end else begin
                rs_d   = 1'b1;
                data_d = rdChar;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            row_q     <= 1'b0;
            col_q     <= 4'd0;
            pending_q <= 1'b0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            rs_q      <= 1'b0;
            data_q    <= 8'h00;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            col_q     <= col_d;
            pending_q <= pending_d;
            busy_q    <= busy_d;
            valid_q   <= valid_d;
            rs_q      <= rs_d;
            data_q    <= data_d;
            done_q    <= done_d;
        end
    end

    assign busy       = busy_q;
    assign cmd_valid  = valid_q;
    assign cmd_rs     = rs_q;
    assign cmd_data   = data_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_lcd_frame_feeder.sv
// Self-checking bench for lcd_frame_feeder: a frame-level reference model checked every cycle,
// plus directed scenarios with literal expected words and cycle counts.
module tb_lcd_frame_feeder;

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic       wr_row;
    logic [3:0] wr_col;
    logic [7:0] wr_char;
    logic       refresh;
    logic       busy;
    logic       cmd_valid;
    logic       cmd_rs;
    logic [7:0] cmd_data;
    logic       cmd_ready;
    logic       frame_done;

    logic       s_wr_en;
    logic       s_wr_row;
    logic [3:0] s_wr_col;
    logic [7:0] s_wr_char;
    logic       s_refresh;
    logic       s_busy;
    logic       s_valid;
    logic       s_rs;
    logic [7:0] s_data;
    logic       s_ready;
    logic       s_done;

    int nCmp  = 0;
    int nFail = 0;

    lcd_frame_feeder dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_row    (wr_row),
        .wr_col    (wr_col),
        .wr_char   (wr_char),
        .refresh   (refresh),
        .busy      (busy),
        .cmd_valid (cmd_valid),
        .cmd_rs    (cmd_rs),
        .cmd_data  (cmd_data),
        .cmd_ready (cmd_ready),
        .frame_done(frame_done)
    );

    lcd_frame_feeder #(
        .COLS(8),
        .ROWS(1)
    ) dutSmall (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (s_wr_en),
        .wr_row    (s_wr_row),
        .wr_col    (s_wr_col),
        .wr_char   (s_wr_char),
        .refresh   (s_refresh),
        .busy      (s_busy),
        .cmd_valid (s_valid),
        .cmd_rs    (s_rs),
        .cmd_data  (s_data),
        .cmd_ready (s_ready),
        .frame_done(s_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: buffer contents now, and as they stood before the latest edge's write.
    logic [7:0] mbuf    [2][16];
    logic [7:0] prevBuf [2][16];
    bit         armed = 0;
    bit         rstAtEdge = 0;

    always @(posedge clk) begin
        armed     = 1;
        rstAtEdge = rst;
        prevBuf   = mbuf;
        if (rst) begin
            for (int r = 0; r < 2; r++)
                for (int c = 0; c < 16; c++)
                    mbuf[r][c] = 8'h20;
        end else if (wr_en) begin
            mbuf[wr_row][wr_col] = wr_char;
        end
    end

    function automatic logic [8:0] expectedWord(input int k);
        int row;
        int pos;
        row = (k % 34) / 17;
        pos = (k % 34) % 17;
        if (pos == 0) return {1'b0, (row == 0) ? 8'h80 : 8'hC0};
        return {1'b1, prevBuf[row][pos-1]};
    endfunction

    int         kPos = 0;
    int         frames = 0;
    bit         prevValid = 0;
    bit         prevHs = 0;
    logic [8:0] held;
    logic [8:0] cur;
    logic [8:0] wlog [$];

    always @(negedge clk) begin
        if (armed) begin
            if (rstAtEdge) begin
                checkOutput("rstOutputs", {20'h0, busy, cmd_valid, cmd_rs, cmd_data, frame_done}, 32'h0);
                kPos      = 0;
                prevValid = 0;
                prevHs    = 0;
            end else begin
                if (prevValid && !prevHs) checkOutput("validHeld", cmd_valid, 1);
                if (cmd_valid) begin
                    checkOutput("busyInXfer", busy, 1);
                    cur = {cmd_rs, cmd_data};
                    if (!prevValid || prevHs) begin
                        checkOutput("word", cur, expectedWord(kPos));
                        held = cur;
                    end else begin
                        checkOutput("stable", cur, held);
                    end
                    if (cmd_ready) begin
                        wlog.push_back(cur);
                        kPos++;
                    end
                end
                if (frame_done) begin
                    checkOutput("busyAtDone", busy, 0);
                    checkOutput("validAtDone", cmd_valid, 0);
                    checkOutput("frameLen", kPos, 34);
                    kPos = 0;
                    frames++;
                end
                prevValid = cmd_valid;
                prevHs    = cmd_valid && cmd_ready;
            end
        end
    end

    int         sFrames = 0;
    logic [8:0] sLog [$];

    always @(negedge clk) begin
        if (armed && !rstAtEdge) begin
            if (s_valid && s_ready) sLog.push_back({s_rs, s_data});
            if (s_done) sFrames++;
        end
    end

    logic [8:0] expFrame [34];

    task automatic buildExpected(input string top);
        logic [7:0] ch;
        expFrame[0]  = 9'h080;
        expFrame[17] = 9'h0C0;
        for (int c = 0; c < 16; c++) begin
            ch = (c < top.len()) ? top[c] : 8'h20;
            expFrame[1+c]  = {1'b1, ch};
            expFrame[18+c] = 9'h120;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic stepN(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic applyStimulus(input logic row, input logic [3:0] col, input logic [7:0] ch);
        wr_en = 1; wr_row = row; wr_col = col; wr_char = ch;
        step();
        wr_en = 0;
    endtask

    task automatic sWrite(input logic row, input logic [3:0] col, input logic [7:0] ch);
        s_wr_en = 1; s_wr_row = row; s_wr_col = col; s_wr_char = ch;
        step();
        s_wr_en = 0;
    endtask

    task automatic pulseRefresh();
        refresh = 1;
        step();
        refresh = 0;
    endtask

    task automatic waitFrame(output int cycles);
        cycles = 0;
        while (!frame_done && cycles < 400) begin
            step();
            cycles++;
        end
        if (!frame_done) checkOutput("frameTimeout", 0, 1);
    endtask

    task automatic sWaitFrame();
        int c = 0;
        while (!s_done && c < 200) begin
            step();
            c++;
        end
        if (!s_done) checkOutput("smallTimeout", 0, 1);
    endtask

    task automatic checkFrame(input string name);
        checkOutput({name, "Len"}, wlog.size(), 34);
        for (int i = 0; i < 34; i++) checkOutput(name, (i < wlog.size()) ? wlog[i] : 9'h1FF, expFrame[i]);
    endtask

    initial begin
        int         cyc;
        int         f0;
        int         g;
        logic [15:0] pat;

        rst = 1; wr_en = 0; wr_row = 0; wr_col = 0; wr_char = 0; refresh = 0; cmd_ready = 1;
        s_wr_en = 0; s_wr_row = 0; s_wr_col = 0; s_wr_char = 0; s_refresh = 0; s_ready = 1;
        stepN(3);
        rst = 0;
        step();

        // Reset held for three cycles in the middle of a transfer.
        applyStimulus(1'b0, 4'd3, "A");
        pulseRefresh();
        stepN(8);
        rst = 1;
        stepN(3);
        rst = 0;
        checkOutput("rstValid", cmd_valid, 0);
        checkOutput("rstBusy", busy, 0);
        stepN(2);
        checkOutput("noDoneAfterRst", frames, 0);
        wlog.delete();
        pulseRefresh();
        waitFrame(cyc);
        buildExpected("");
        checkFrame("blankFrame");

        // HELLO frame with the driver always ready.
        step();
        applyStimulus(1'b0, 4'd0, "H");
        applyStimulus(1'b0, 4'd1, "E");
        applyStimulus(1'b0, 4'd2, "L");
        applyStimulus(1'b0, 4'd3, "L");
        applyStimulus(1'b0, 4'd4, "O");
        wlog.delete();
        f0 = frames;
        pulseRefresh();
        waitFrame(cyc);
        checkOutput("doneLatency", cyc + 1, 35);
        buildExpected("HELLO");
        checkFrame("helloFrame");
        checkOutput("helloH", wlog[1], 9'h148);
        checkOutput("helloO", wlog[5], 9'h14F);
        checkOutput("helloPad", wlog[6], 9'h120);
        checkOutput("row1Addr", wlog[17], 9'h0C0);
        stepN(10);
        checkOutput("helloOneFrame", frames - f0, 1);

        // Stalling driver: same word order, one frame.
        wlog.delete();
        f0 = frames;
        pat = 16'b1011_0010_0111_0100;
        pulseRefresh();
        g = 0;
        while (!frame_done && g < 400) begin
            cmd_ready = pat[g % 16];
            step();
            g++;
        end
        if (!frame_done) checkOutput("stallTimeout", 0, 1);
        cmd_ready = 1;
        checkFrame("stallFrame");
        stepN(10);
        checkOutput("stallOneFrame", frames - f0, 1);

        // Writes during a transfer: captured cell and pending re-send.
        wlog.delete();
        f0 = frames;
        pulseRefresh();
        stepN(3);
        applyStimulus(1'b1, 4'd15, "Z");
        waitFrame(cyc);
        checkOutput("zInFirst", wlog[33], 9'h15A);
        wlog.delete();
        g = 0;
        while (!(kPos == 33 && cmd_valid) && g < 200) begin
            step();
            g++;
        end
        checkOutput("reachLastChar", kPos, 33);
        applyStimulus(1'b1, 4'd15, "W");
        checkOutput("doneAfterLast", frame_done, 1);
        checkOutput("zInPending", wlog[33], 9'h15A);
        g = 0;
        while (!cmd_valid && g < 10) begin
            step();
            g++;
        end
        checkOutput("restartGap", g, 2);
        wlog.delete();
        waitFrame(cyc);
        checkOutput("wInThird", wlog[33], 9'h157);
        stepN(10);
        checkOutput("writeFrames", frames - f0, 3);
        checkOutput("idleAfter", cmd_valid, 0);

        // Repeated refresh while busy collapses into one extra frame.
        f0 = frames;
        pulseRefresh();
        stepN(5);
        pulseRefresh();
        stepN(3);
        pulseRefresh();
        stepN(3);
        pulseRefresh();
        waitFrame(cyc);
        stepN(2);
        waitFrame(cyc);
        stepN(10);
        checkOutput("refreshFrames", frames - f0, 2);
        checkOutput("refreshIdle", cmd_valid, 0);

        // Out-of-range writes on an 8x1 instance.
        sWrite(1'b0, 4'd7, "Q");
        sLog.delete();
        s_refresh = 1;
        step();
        s_refresh = 0;
        step();
        sWrite(1'b0, 4'd15, "X");
        sWrite(1'b1, 4'd0, "Y");
        sWaitFrame();
        stepN(8);
        checkOutput("smallFrames1", sFrames, 1);
        checkOutput("smallLen1", sLog.size(), 9);
        checkOutput("smallAddr1", sLog[0], 9'h080);
        checkOutput("smallQ1", sLog[8], 9'h151);
        sLog.delete();
        s_refresh = 1;
        step();
        s_refresh = 0;
        sWaitFrame();
        stepN(3);
        checkOutput("smallFrames2", sFrames, 2);
        checkOutput("smallLen2", sLog.size(), 9);
        checkOutput("smallAddr2", sLog[0], 9'h080);
        for (int i = 1; i < 8; i++) checkOutput("smallSpace", (i < sLog.size()) ? sLog[i] : 9'h1FF, 9'h120);
        checkOutput("smallQ2", sLog[8], 9'h151);

        $display("== %0d vectors applied, %0d miscompares ==", nCmp, nFail);
        $finish;
    end

endmodule
